// File: rtl/if_stage.sv
// rtl/if_stage.sv - instruction-fetch stage: PC register, IF/ID register, stall/branch handling
// Optional IF_BOUNDS_CHECK_EN: stop fetching and flag fetch_fault when PCaddr >= IMEM_DEPTH.
module if_stage #(
    parameter logic [15:0] RESET_PC   = 16'h0000,
    parameter int          IMEM_DEPTH = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        br_taken,
    input  logic [15:0] br_target,
    output logic [15:0] PCaddr,
    input  logic [15:0] Instr,
    output logic [15:0] ifid_instr,
    output logic [15:0] ifid_pc1,
    output logic        ifid_valid,
    output logic [15:0] fetch_count,
    output logic        fetch_fault
);

`ifdef IF_BOUNDS_CHECK_EN
    localparam logic BOUNDS_EN = 1'b1;
`else
    localparam logic BOUNDS_EN = 1'b0;
`endif

    logic [15:0] pc_plus1;
    logic        out_of_range;
    logic        bounds_stop;

    assign pc_plus1     = PCaddr + 16'd1;
    assign out_of_range = ({16'h0000, PCaddr} >= 32'(IMEM_DEPTH));
    // Constant-folds to 0 when the bounds check is compiled out.
    assign bounds_stop  = BOUNDS_EN & out_of_range;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            PCaddr      <= RESET_PC;
            ifid_instr  <= 16'h0000;
            ifid_pc1    <= 16'h0000;
            ifid_valid  <= 1'b0;
            fetch_count <= 16'h0000;
        end else if (br_taken) begin
            // Redirect wins over stall; the wrong-path fetch becomes a bubble.
            PCaddr      <= br_target;
            ifid_instr  <= 16'h0000;
            ifid_pc1    <= 16'h0000;
            ifid_valid  <= 1'b0;
        end else if (stall) begin
            PCaddr      <= PCaddr;
        end else if (bounds_stop) begin
            ifid_instr  <= 16'h0000;
            ifid_pc1    <= 16'h0000;
            ifid_valid  <= 1'b0;
        end else begin
            PCaddr      <= pc_plus1;
            ifid_instr  <= Instr;
            ifid_pc1    <= pc_plus1;
            ifid_valid  <= 1'b1;
            fetch_count <= fetch_count + 16'd1;
        end
    end

`ifdef IF_BOUNDS_CHECK_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_fault <= 1'b0;
        end else if (!br_taken && !stall && bounds_stop) begin
            fetch_fault <= 1'b1;
        end
    end
`else
    assign fetch_fault = 1'b0;
`endif

endmodule

// File: tb/tb_if_stage.sv
// tb/tb_if_stage.sv - directed self-checking bench for if_stage
module tb_if_stage;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        br_taken;
    logic [15:0] br_target;
    logic [15:0] PCaddr;
    logic [15:0] Instr;
    logic [15:0] ifid_instr;
    logic [15:0] ifid_pc1;
    logic        ifid_valid;
    logic [15:0] fetch_count;
    logic        fetch_fault;

    logic [15:0] mem [0:255];
    int checks;
    int errors;

    if_stage #(.RESET_PC(16'h0000), .IMEM_DEPTH(64)) dut (
        .clk        (clk),
        .rst        (rst),
        .stall      (stall),
        .br_taken   (br_taken),
        .br_target  (br_target),
        .PCaddr     (PCaddr),
        .Instr      (Instr),
        .ifid_instr (ifid_instr),
        .ifid_pc1   (ifid_pc1),
        .ifid_valid (ifid_valid),
        .fetch_count(fetch_count),
        .fetch_fault(fetch_fault)
    );

    assign Instr = mem[PCaddr[7:0]];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_ifid(input string tag, input logic [15:0] pc, input logic [15:0] ins,
                              input logic [15:0] pc1, input logic vld, input logic [15:0] cnt);
        check({tag, ".PCaddr"}, PCaddr, pc);
        check({tag, ".ifid_instr"}, ifid_instr, ins);
        check({tag, ".ifid_pc1"}, ifid_pc1, pc1);
        check({tag, ".ifid_valid"}, {15'h0, ifid_valid}, {15'h0, vld});
        check({tag, ".fetch_count"}, fetch_count, cnt);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        for (int i = 0; i < 256; i++) mem[i] = 16'h8000 | 16'(i);
        mem[0] = 16'h2000;
        mem[1] = 16'h6000;
        mem[2] = 16'h0000;
        mem[3] = 16'h1000;
        mem[4] = 16'h7000;

        rst = 1'b0; stall = 1'b0; br_taken = 1'b0; br_target = 16'h0000;
        #2 rst = 1'b1;
        #1;
        check_ifid("reset", 16'h0000, 16'h0000, 16'h0000, 1'b0, 16'h0000);
        check("reset.fetch_fault", {15'h0, fetch_fault}, 16'h0000);
        step();
        rst = 1'b0;

        // Free-running fetch of the preloaded program.
        step(); check_ifid("run0", 16'h0001, 16'h2000, 16'h0001, 1'b1, 16'h0001);
        step(); check_ifid("run1", 16'h0002, 16'h6000, 16'h0002, 1'b1, 16'h0002);
        step(); check_ifid("run2", 16'h0003, 16'h0000, 16'h0003, 1'b1, 16'h0003);
        step(); check_ifid("run3", 16'h0004, 16'h1000, 16'h0004, 1'b1, 16'h0004);
        step(); check_ifid("run4", 16'h0005, 16'h7000, 16'h0005, 1'b1, 16'h0005);

        // Taken branch from PC 5 to 8: one bubble, then the target instruction.
        br_taken = 1'b1; br_target = 16'h0008;
        step(); br_taken = 1'b0;
        check_ifid("br_bubble", 16'h0008, 16'h0000, 16'h0000, 1'b0, 16'h0005);
        step(); check_ifid("br_target", 16'h0009, 16'h8008, 16'h0009, 1'b1, 16'h0006);

        // Branch and stall together: branch wins.
        br_taken = 1'b1; stall = 1'b1; br_target = 16'h0002;
        step(); br_taken = 1'b0; stall = 1'b0;
        check_ifid("br_stall", 16'h0002, 16'h0000, 16'h0000, 1'b0, 16'h0006);
        step(); check_ifid("after_br_stall", 16'h0003, 16'h0000, 16'h0003, 1'b1, 16'h0007);

        // Three-cycle stall at PC 3.
        stall = 1'b1;
        step(); check_ifid("stall1", 16'h0003, 16'h0000, 16'h0003, 1'b1, 16'h0007);
        step(); check_ifid("stall2", 16'h0003, 16'h0000, 16'h0003, 1'b1, 16'h0007);
        step(); check_ifid("stall3", 16'h0003, 16'h0000, 16'h0003, 1'b1, 16'h0007);
        stall = 1'b0;
        step(); check_ifid("unstall", 16'h0004, 16'h1000, 16'h0004, 1'b1, 16'h0008);

        step(); step(); step();
        check_ifid("run_to7", 16'h0007, 16'h8006, 16'h0007, 1'b1, 16'h000B);

        // Asynchronous reset mid-cycle, with a pending branch discarded.
        br_taken = 1'b1; br_target = 16'h0020;
        #2 rst = 1'b1;
        #1;
        check_ifid("async_rst", 16'h0000, 16'h0000, 16'h0000, 1'b0, 16'h0000);
        check("async_rst.fetch_fault", {15'h0, fetch_fault}, 16'h0000);
        step();
        br_taken = 1'b0;
        rst = 1'b0;

        // Branch to the last in-range word and run past the end.
        br_taken = 1'b1; br_target = 16'd63;
        step(); br_taken = 1'b0;
        check_ifid("br63", 16'd63, 16'h0000, 16'h0000, 1'b0, 16'h0000);
        step(); check_ifid("load63", 16'd64, 16'h803F, 16'd64, 1'b1, 16'h0001);
        step();
`ifdef IF_BOUNDS_CHECK_EN
        check_ifid("oob1", 16'd64, 16'h0000, 16'h0000, 1'b0, 16'h0001);
        check("oob1.fetch_fault", {15'h0, fetch_fault}, 16'h0001);
        step();
        check_ifid("oob2", 16'd64, 16'h0000, 16'h0000, 1'b0, 16'h0001);
        check("oob2.fetch_fault", {15'h0, fetch_fault}, 16'h0001);
`else
        check_ifid("past64", 16'd65, 16'h8040, 16'd65, 1'b1, 16'h0002);
        check("past64.fetch_fault", {15'h0, fetch_fault}, 16'h0000);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
